// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencing controller.
// Contents: stall bus width and encodings, FSM state codes.
// Stall bus bit order is {wb,mem,ex,id,if,pc}, bit0 = pc.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_t;

  // Hold encodings: ID hazards freeze pc/if/id, EX multi-cycle ops also freeze ex.
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MC   = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating performance counters for pipe_ctrl.
// Ports: clk, rst (sync, active-high), stall_any / flush event inputs,
//        perf_stall_cyc (32b) and perf_flush_cnt (16b) counter outputs.
// Counters reset to zero and stick at all-ones instead of wrapping.
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any,
  input  logic        flush,
  output logic [31:0] perf_stall_cyc,
  output logic [15:0] perf_flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_any && (perf_stall_cyc != '1)) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if (flush && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage core.
// Ports: clk/rst (sync, active-high); ID/EX stall, multi-cycle and divide
//        requests; MEM exception + target PC; stall vector, flush, new PC,
//        multi-cycle index and divider start/cancel/timeout outputs.
// Optional PIPE_CTRL_PERF_EN adds perf_stall_cyc_o / perf_flush_cnt_o.
// All outputs are combinational from state and inputs (same-cycle effect).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             mc_req_i,
  input  logic [CNT_W-1:0] mc_len_i,
  input  logic             div_req_i,
  input  logic             div_ready_i,
  input  logic             excp_i,
  input  logic [31:0]      excp_pc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic [CNT_W-1:0] ex_cnt_o,
  output logic             div_start_o,
  output logic             div_cancel_o,
  output logic             div_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_stall_cyc_o,
  output logic [15:0]      perf_flush_cnt_o
`endif
);

  localparam int WD_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  // Watchdog value seen on the last permitted DIV cycle (first DIV cycle sees 0).
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [WD_W-1:0]  wd, wd_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len_q <= '0;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
      wd    <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    len_nxt       = len_q;
    wd_nxt        = wd;
    stall_o       = STALL_NONE;
    flush_o       = 1'b0;
    new_pc_o      = '0;
    ex_cnt_o      = (state == ST_MC) ? cnt : '0;
    div_start_o   = 1'b0;
    div_cancel_o  = 1'b0;
    div_timeout_o = 1'b0;

    if (excp_i) begin
      // Flush overrides everything; any in-flight op is abandoned.
      flush_o   = 1'b1;
      new_pc_o  = excp_pc_i;
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      len_nxt   = '0;
      wd_nxt    = '0;
      if (state == ST_DIV) begin
        div_cancel_o = 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_req_i) begin
            div_start_o = 1'b1;
            stall_o     = STALL_EX;
            state_nxt   = ST_DIV;
            wd_nxt      = '0;
          end else if (mc_req_i && (mc_len_i != '0)) begin
            // This request cycle is the first stalled cycle (index 0).
            stall_o   = STALL_EX;
            state_nxt = ST_MC;
            cnt_nxt   = CNT_W'(1);
            len_nxt   = mc_len_i;
          end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
          end
        end

        ST_MC: begin
          if (cnt < len_q) begin
            stall_o = STALL_EX;
            cnt_nxt = cnt + CNT_W'(1);
          end else begin
            // Release cycle: EX result moves on, stall already lasted len_q cycles.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end

        ST_DIV: begin
          if (div_ready_i) begin
            state_nxt = ST_IDLE;
            wd_nxt    = '0;
          end else if (wd == WD_LAST) begin
            div_timeout_o = 1'b1;
            div_cancel_o  = 1'b1;
            state_nxt     = ST_IDLE;
            wd_nxt        = '0;
          end else begin
            div_start_o = 1'b1;
            stall_o     = STALL_EX;
            wd_nxt      = wd + WD_W'(1);
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          len_nxt   = '0;
          wd_nxt    = '0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall_any      (|stall_o),
    .flush          (flush_o),
    .perf_stall_cyc (perf_stall_cyc_o),
    .perf_flush_cnt (perf_flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl.
// Table-driven IDLE vectors, hand-written multi-cycle sequences, then
// random stimulus against an operation-level reference model.
module tb_pipe_ctrl;

  localparam int CNT_W       = 2;
  localparam int DIV_TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_id_i;
  logic             mc_req_i;
  logic [CNT_W-1:0] mc_len_i;
  logic             div_req_i;
  logic             div_ready_i;
  logic             excp_i;
  logic [31:0]      excp_pc_i;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic [31:0]      new_pc_o;
  logic [CNT_W-1:0] ex_cnt_o;
  logic             div_start_o;
  logic             div_cancel_o;
  logic             div_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]      perf_stall_cyc_o;
  logic [15:0]      perf_flush_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .mc_req_i      (mc_req_i),
    .mc_len_i      (mc_len_i),
    .div_req_i     (div_req_i),
    .div_ready_i   (div_ready_i),
    .excp_i        (excp_i),
    .excp_pc_i     (excp_pc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .ex_cnt_o      (ex_cnt_o),
    .div_start_o   (div_start_o),
    .div_cancel_o  (div_cancel_o),
    .div_timeout_o (div_timeout_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
  );

  // Output bundle: {stall, flush, new_pc, ex_cnt, div_start, div_cancel, div_timeout}
  typedef logic [43:0] ovec_t;
  ovec_t act;
  assign act = {stall_o, flush_o, new_pc_o, ex_cnt_o, div_start_o, div_cancel_o, div_timeout_o};

  int checks   = 0;
  int failures = 0;

  function automatic ovec_t mk(logic [5:0] s, logic f, logic [31:0] pc, logic [1:0] c,
                               logic st, logic ca, logic to);
    return {s, f, pc, c, st, ca, to};
  endfunction

  localparam ovec_t EXP_IDLE = '0;

  task automatic check(input string name, input ovec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got stall=%b flush=%b pc=%h cnt=%0d start=%b cancel=%b tout=%b want stall=%b flush=%b pc=%h cnt=%0d start=%b cancel=%b tout=%b",
               name, act[43:38], act[37], act[36:5], act[4:3], act[2], act[1], act[0],
               exp[43:38], exp[37], exp[36:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic set_in(input logic sr, input logic mc, input logic [1:0] len, input logic dv,
                        input logic rdy, input logic ex, input logic [31:0] pc);
    stallreq_id_i = sr;
    mc_req_i      = mc;
    mc_len_i      = len;
    div_req_i     = dv;
    div_ready_i   = rdy;
    excp_i        = ex;
    excp_pc_i     = pc;
  endtask

  // Leaves the bench at a falling edge with rst low and the DUT idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: tracks the operation in flight, not controller state.
  // kind: 0 none, 1 multi-cycle op, 2 divide
  int m_kind, m_done, m_len, m_age;

  task automatic model_step(input logic sr, input logic mc, input logic [1:0] len, input logic dv,
                            input logic rdy, input logic ex, input logic [31:0] pc,
                            output ovec_t exp);
    logic [5:0]  s;
    logic        f, st, ca, to;
    logic [31:0] np;
    int          c;
    s = 6'b000000; f = 0; st = 0; ca = 0; to = 0; np = 32'h0; c = 0;
    if (m_kind == 1) c = m_done;
    if (ex) begin
      f = 1; np = pc;
      if (m_kind == 2) ca = 1;
      m_kind = 0; m_done = 0; m_len = 0; m_age = 0;
    end else if (m_kind == 0) begin
      if (dv) begin
        s = 6'b001111; st = 1; m_kind = 2; m_age = 0;
      end else if (mc && len != 0) begin
        s = 6'b001111; m_kind = 1; m_done = 1; m_len = int'(len);
      end else if (sr) begin
        s = 6'b000111;
      end
    end else if (m_kind == 1) begin
      // Stall continues until len cycles of stall have been issued in total.
      if (m_done < m_len) begin
        s = 6'b001111; m_done = m_done + 1;
      end else begin
        m_kind = 0; m_done = 0;
      end
    end else begin
      m_age = m_age + 1;  // number of this cycle within the divide (1-based)
      if (rdy) begin
        m_kind = 0;
      end else if (m_age == DIV_TIMEOUT) begin
        to = 1; ca = 1; m_kind = 0;
      end else begin
        s = 6'b001111; st = 1;
      end
    end
    exp = {s, f, np, 2'(c), st, ca, to};
  endtask

  typedef struct {
    logic        sr, mc;
    logic [1:0]  len;
    logic        dv, rdy, ex;
    logic [31:0] pc;
    ovec_t       exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit");
  end

  initial begin
    ovec_t exp;
    ovec_t busy;
    busy = mk(6'b001111, 0, 32'h0, 2'd0, 1, 0, 0);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);

    // Reset state
    do_reset();
    #1 check("reset_idle", EXP_IDLE);

    // Single-cycle IDLE behaviour
    tbl[0] = '{0, 0, 2'd0, 0, 0, 0, 32'h0,         EXP_IDLE};
    tbl[1] = '{1, 0, 2'd0, 0, 0, 0, 32'h0,         mk(6'b000111, 0, 32'h0, 2'd0, 0, 0, 0)};
    tbl[2] = '{0, 1, 2'd0, 0, 0, 0, 32'h0,         EXP_IDLE};
    tbl[3] = '{0, 1, 2'd3, 0, 0, 0, 32'h0,         mk(6'b001111, 0, 32'h0, 2'd0, 0, 0, 0)};
    tbl[4] = '{0, 0, 2'd0, 1, 0, 0, 32'h0,         busy};
    tbl[5] = '{0, 0, 2'd0, 0, 1, 0, 32'h0,         EXP_IDLE};
    tbl[6] = '{0, 0, 2'd0, 0, 0, 1, 32'h0000_0100, mk(6'b000000, 1, 32'h0000_0100, 2'd0, 0, 0, 0)};
    tbl[7] = '{1, 1, 2'd2, 1, 0, 1, 32'hBFC0_0380, mk(6'b000000, 1, 32'hBFC0_0380, 2'd0, 0, 0, 0)};
    tbl[8] = '{1, 1, 2'd2, 1, 0, 0, 32'h0,         busy};
    tbl[9] = '{1, 1, 2'd1, 0, 0, 0, 32'h0,         mk(6'b001111, 0, 32'h0, 2'd0, 0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_in(tbl[i].sr, tbl[i].mc, tbl[i].len, tbl[i].dv, tbl[i].rdy, tbl[i].ex, tbl[i].pc);
      #1 check($sformatf("table%0d", i), tbl[i].exp);
    end

    // Multi-cycle op of length 2
    do_reset();
    set_in(0, 1, 2'd2, 0, 0, 0, 32'h0);
    #1 check("mc2_c0", mk(6'b001111, 0, 32'h0, 2'd0, 0, 0, 0));
    @(negedge clk); #1 check("mc2_c1", mk(6'b001111, 0, 32'h0, 2'd1, 0, 0, 0));
    @(negedge clk); #1 check("mc2_release", mk(6'b000000, 0, 32'h0, 2'd2, 0, 0, 0));
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    #1 check("mc2_idle", EXP_IDLE);

    // Divide with ready five cycles after the request
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    #1 check("div_c0", busy);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1 check($sformatf("div_c%0d", k), busy);
    end
    @(negedge clk); set_in(0, 0, 0, 1, 1, 0, 32'h0);
    #1 check("div_ready", EXP_IDLE);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    #1 check("div_after_ready", EXP_IDLE);

    // Divide watchdog: 64th DIV cycle aborts
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    #1 check("wd_req", busy);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    for (int k = 1; k <= DIV_TIMEOUT - 1; k++) begin
      #1 check($sformatf("wd_busy%0d", k), busy);
      @(negedge clk);
    end
    #1 check("wd_timeout", mk(6'b000000, 0, 32'h0, 2'd0, 0, 1, 1));
    @(negedge clk); #1 check("wd_idle", EXP_IDLE);

    // Exception during DIV cycle 3
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 1, 32'h0000_0020);
    #1 check("div_excp", mk(6'b000000, 1, 32'h0000_0020, 2'd0, 0, 1, 0));
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    #1 check("div_excp_idle", EXP_IDLE);

    // All requests together: divide taken, mc ignored
    do_reset();
    set_in(1, 1, 2'd2, 1, 0, 0, 32'h0);
    #1 check("simul_req", busy);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    #1 check("simul_in_div", busy);
    @(negedge clk); set_in(0, 0, 0, 0, 1, 0, 32'h0);
    #1 check("simul_ready", EXP_IDLE);

    // Reset while dividing: no cancel pulse, back to idle
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    #1 check_bit("rst_div_no_cancel", div_cancel_o, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1 check("rst_div_idle", EXP_IDLE);

    // Random stimulus against the reference model
    do_reset();
    m_kind = 0; m_done = 0; m_len = 0; m_age = 0;
    for (int n = 0; n < 4000; n++) begin
      logic sr, mc, dv, rdy, ex;
      logic [1:0] len;
      logic [31:0] pc;
      sr  = ($urandom % 4) == 0;
      mc  = ($urandom % 6) == 0;
      len = 2'($urandom % 4);
      dv  = ($urandom % 10) == 0;
      rdy = ($urandom % 40) == 0;
      ex  = ($urandom % 60) == 0;
      pc  = $urandom;
      set_in(sr, mc, len, dv, rdy, ex, pc);
      model_step(sr, mc, len, dv, rdy, ex, pc, exp);
      #1 check($sformatf("rand%0d", n), exp);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage core. It arbitrates stall requests from ID and EX, and sequences multi-cycle EX operations (fixed-length accumulate, variable-latency divide). It generates the per-stage stall vector and the exception flush consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Stall and flush take effect in the same cycle as the request, and the FSM advances at clk.

Parameters:
CNT_W, 2, width of multi-cycle length and cycle counter (max op length 2^CNT_W-1)
DIV_TIMEOUT, 64, cycles in DIV before the watchdog aborts the divide

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stallreq_id_i  in  1  ID load-use / operand hazard stall request
mc_req_i  in  1  EX requests fixed-length multi-cycle op (madd/msub)
mc_len_i  in  CNT_W  stall cycles required by multi-cycle op
div_req_i  in  1  EX requests divide
div_ready_i  in  1  divider result valid
excp_i  in  1  exception/eret detected in MEM
excp_pc_i  in  32  handler / return PC
stall_o  out  6  {wb,mem,ex,id,if,pc} hold enables, bit0=pc
flush_o  out  1  clear all pipeline registers
new_pc_o  out  32  PC to load when flush_o=1
ex_cnt_o  out  CNT_W  current cycle index of multi-cycle op, to EX
div_start_o  out  1  divider start/hold
div_cancel_o  out  1  one-cycle divider abort
div_timeout_o  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; cnt, len_q and watchdog cleared.
  - All outputs 0 combinationally while in IDLE with no requests.
  - Reset mid-DIV: no div_cancel_o pulse. The divider shares rst.
- Outputs are combinational from state plus inputs. State, counters and len_q are registered.
- Priority: excp_i > div_req_i > mc_req_i > stallreq_id_i.
- FSM states: IDLE, MC, DIV.
- IDLE:
  - excp_i: flush_o=1, new_pc_o=excp_pc_i, stall_o=0. Stay in IDLE.
  - div_req_i: div_start_o=1, stall_o=6'b001111. Next state DIV, watchdog<=0.
  - mc_req_i with mc_len_i>0: stall_o=6'b001111, ex_cnt_o=0. Next state MC, cnt<=1, len_q<=mc_len_i.
  - mc_req_i with mc_len_i=0: no stall, no state change.
  - stallreq_id_i: stall_o=6'b000111. No state change.
  - div_ready_i is ignored in IDLE.
- MC:
  - ex_cnt_o=cnt.
  - While cnt<len_q: stall_o=6'b001111, cnt<=cnt+1.
  - When cnt==len_q: stall_o=0 (EX result advances), next state IDLE, cnt<=0.
  - Total stalled cycles = len_q. The counter never wraps because len_q ≤ 2^CNT_W-1.
  - mc_req_i/div_req_i are ignored in MC. EX holds its request stable while stalled.
  - stallreq_id_i is subsumed (already covered by 001111).
- DIV:
  - div_start_o=1 and stall_o=6'b001111 until div_ready_i.
  - On the div_ready_i cycle: stall_o=0, div_start_o=0, next state IDLE.
  - Watchdog increments each DIV cycle. If it reaches DIV_TIMEOUT-1 without div_ready_i: div_timeout_o=1 and div_cancel_o=1 for one cycle, stall_o=0, next state IDLE.
  - div_ready_i and timeout in the same cycle: ready wins, no timeout pulse.
- excp_i in MC or DIV:
  - flush_o=1, stall_o=0, next state IDLE, counters cleared.
  - If in DIV: div_cancel_o=1 that cycle, div_start_o=0.
- excp_i together with any request: flush wins and the request is dropped.

Optional Feature:
PIPE_CTRL_PERF_EN:
- When defined, adds outputs perf_stall_cyc_o[31:0] and perf_flush_cnt_o[15:0]. Both reset to 0 and saturate at all-ones.
- perf_stall_cyc_o increments in each cycle with stall_o!=0.
- perf_flush_cnt_o increments in each cycle with flush_o=1.
- When undefined, the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- defines.v gains: StallBus width 6; stall encodings StallNone=6'b000000, StallId=6'b000111, StallEx=6'b001111; FSM state codes for IDLE, MC and DIV.
- One natural sub-module: pipe_ctrl_perf, holding the saturating counters. It is instantiated only under PIPE_CTRL_PERF_EN.

Test Plan:
- Reset check: rst=1 for 2 cycles, then idle -> stall_o=0, flush_o=0, div_start_o=0, ex_cnt_o=0.
- mc_req_i=1 with mc_len_i=2 -> stall_o=001111 for 2 cycles with ex_cnt_o=0 then 1; 3rd cycle stall_o=0 and ex_cnt_o=2; back to IDLE.
- div_req_i, then div_ready_i asserted 5 cycles later -> div_start_o and stall_o=001111 for 5 cycles; ready cycle stall_o=0, div_start_o=0.
- DIV with no ready (DIV_TIMEOUT=64) -> on the 64th DIV cycle, div_timeout_o=1 and div_cancel_o=1 for one cycle; then IDLE.
- excp_i=1 with excp_pc_i=0x0000_0020 in DIV cycle 3 -> flush_o=1, new_pc_o=0x20, div_cancel_o=1, stall_o=0; next cycle IDLE.
- Simultaneous stallreq_id_i, mc_req_i and div_req_i in IDLE -> div path taken (stall_o=001111, div_start_o=1); mc request ignored.
